// File: rtl/dmem_mmio.sv
// Word-addressed data RAM plus a small memory-mapped IO block: synchronised input
// channels with sticky change flags, output registers with update pulses, and a level irq.
module dmem_mmio #(
    parameter int ADDR_W = 14,
    parameter int N_IN   = 2,
    parameter int IN_W   = 8,
    parameter int N_OUT  = 3,
    parameter int OUT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [3:0]             be,
    input  logic [31:0]            ask_addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    input  logic [N_IN*IN_W-1:0]   in_data,
    output logic [N_OUT*OUT_W-1:0] out_data,
    output logic [N_OUT-1:0]       out_upd,
    output logic                   irq
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [5:0] IDX_IRQ_EN = 6'd14;
    localparam logic [5:0] IDX_STATUS = 6'd15;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] ram_idx;
    logic [5:0]        io_idx;
    logic              is_io;
    logic              ram_we;
    logic              io_we;
    logic              unused_addr;

    assign ram_idx     = ask_addr[ADDR_W+1:2];
    assign io_idx      = ask_addr[7:2];
    assign is_io       = ask_addr[31];
    assign ram_we      = rst_n & we & ~is_io;
    assign io_we       = rst_n & we & is_io;
    assign unused_addr = ^{ask_addr[30:8], ask_addr[1:0]};

    logic [N_IN*IN_W-1:0]   sync1_q, sync2_q, prev_q;
    logic [N_IN-1:0]        status_q, status_d;
    logic [N_IN-1:0]        irq_en_q, irq_en_d;
    logic [N_IN-1:0]        status_clr;
    logic [N_IN-1:0]        chg;
    logic [N_OUT*OUT_W-1:0] out_q, out_d;
    logic [N_OUT-1:0]       upd_q, upd_d;
    logic                   irq_q, irq_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            io_rdata;
    logic [31:0]            ram_wr_word;

    for (genvar k = 0; k < N_IN; k++) begin : g_chg
        assign chg[k] = sync2_q[k*IN_W +: IN_W] != prev_q[k*IN_W +: IN_W];
    end

    // Byte merge against the current word; the read port sees this same pre-write word.
    always_comb begin
        ram_wr_word = mem[ram_idx];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ram_wr_word[b*8 +: 8] = wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= ram_wr_word;
    end

    always_comb begin
        io_rdata = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (io_idx == 6'(k)) io_rdata[IN_W-1:0] = sync2_q[k*IN_W +: IN_W];
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (io_idx == 6'(N_IN + j)) io_rdata[OUT_W-1:0] = out_q[j*OUT_W +: OUT_W];
        end
        if (io_idx == IDX_IRQ_EN) io_rdata[N_IN-1:0] = irq_en_q;
        if (io_idx == IDX_STATUS) io_rdata[N_IN-1:0] = status_q;
    end

    assign rdata_d = is_io ? io_rdata : mem[ram_idx];

    always_comb begin
        out_d = out_q;
        upd_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (io_we && io_idx == 6'(N_IN + j)) begin
                out_d[j*OUT_W +: OUT_W] = wdata[OUT_W-1:0];
                upd_d[j]                = 1'b1;
            end
        end
        irq_en_d = irq_en_q;
        if (io_we && io_idx == IDX_IRQ_EN) irq_en_d = wdata[N_IN-1:0];
        status_clr = '0;
        if (io_we && io_idx == IDX_STATUS) status_clr = wdata[N_IN-1:0];
        // A new change in the same cycle as its clear keeps the flag set.
        status_d = (status_q & ~status_clr) | chg;
        irq_d    = |(status_q & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            status_q <= '0;
            irq_en_q <= '0;
            out_q    <= '0;
            upd_q    <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            sync1_q  <= in_data;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            out_q    <= out_d;
            upd_q    <= upd_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign out_data = out_q;
    assign out_upd  = upd_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio at default parameters: read results are queued when the
// access is driven and compared when rdata appears one cycle later.
module tb_dmem_mmio;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  be;
    logic [31:0] ask_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] in_data;
    logic [47:0] out_data;
    logic [2:0]  out_upd;
    logic        irq;

    dmem_mmio dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .be       (be),
        .ask_addr (ask_addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .in_data  (in_data),
        .out_data (out_data),
        .out_upd  (out_upd),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          due_q [$];
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] rnd   [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            if (due_q[0] == cyc) chk(tag_q[0], rdata, exp_q[0]);
            else                 chk({tag_q[0], "_missed"}, 1, 0);
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
        end
    end

    task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, input logic chk_rd, input logic [31:0] exp,
                          input string tag);
        we       = w;
        be       = b;
        ask_addr = a;
        wdata    = d;
        if (chk_rd) begin
            due_q.push_back(cyc + 1);
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        access(1'b1, b, a, d, 1'b0, 32'h0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        access(1'b0, 4'h0, a, 32'h0, 1'b1, exp, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; be = 4'h0; ask_addr = '0; wdata = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_upd", out_upd, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1'b1;
        rd(32'h8000_003C, 32'h0, "status_after_rst");

        // RAM: byte enables, aliasing, read-first, be=0, IO space not touching RAM
        wr(32'h0000_0100, 32'h0000_0000, 4'hF);
        wr(32'h0000_0100, 32'hDEAD_BEEF, 4'b0101);
        rd(32'h0000_0100, 32'h00AD_00EF, "ram_be");
        rd(32'h0001_0100, 32'h00AD_00EF, "ram_alias");
        wr(32'h8000_0100, 32'hFFFF_FFFF, 4'hF);
        rd(32'h0000_0100, 32'h00AD_00EF, "ram_io_isolated");
        rd(32'h8000_0000, 32'h0, "in0_readonly");
        wr(32'h0000_0104, 32'h1111_1111, 4'hF);
        access(1'b1, 4'hF, 32'h0000_0104, 32'h2222_2222, 1'b1, 32'h1111_1111, "ram_rdfirst");
        wr(32'h0000_0104, 32'hFFFF_FFFF, 4'h0);
        rd(32'h0000_0104, 32'h2222_2222, "ram_be0");
        for (int i = 0; i < 8; i++) begin
            rnd[i] = $urandom;
            wr(32'h0000_0200 + 32'(i * 4), rnd[i], 4'hF);
        end
        for (int i = 0; i < 8; i++) rd(32'h0000_0200 + 32'(i * 4), rnd[i], "ram_rand");

        // Output registers
        wr(32'h8000_0010, 32'h1234_ABCD, 4'hF);
        chk("out2_data", out_data[47:32], 16'hABCD);
        chk("out2_upd", out_upd, 3'b100);
        idle(1);
        chk("out2_upd_end", out_upd, 3'b000);
        rd(32'h8000_0010, 32'h0000_ABCD, "out2_rd");
        wr(32'h8000_0010, 32'h1234_ABCD, 4'hF);
        chk("out2_upd_same", out_upd, 3'b100);
        wr(32'h8000_0008, 32'hFFFF_5555, 4'h0);
        chk("out0_data", out_data[15:0], 16'h5555);
        chk("out0_upd", out_upd, 3'b001);
        access(1'b1, 4'hF, 32'h8000_0008, 32'h0000_7777, 1'b1, 32'h0000_5555, "io_rdfirst");
        chk("out0_data2", out_data[15:0], 16'h7777);
        wr(32'h8000_0020, 32'hFFFF_FFFF, 4'hF);
        chk("unused_idx_upd", out_upd, 3'b000);
        rd(32'h8000_0020, 32'h0, "unused_idx_rd");
        rd(32'h80FF_FF12, 32'h0000_ABCD, "io_alias");

        // IRQ enable register keeps only N_IN bits
        wr(32'h8000_0038, 32'hFF, 4'hF);
        rd(32'h8000_0038, 32'h3, "irq_en_mask");
        wr(32'h8000_0038, 32'h2, 4'hF);
        rd(32'h8000_0038, 32'h2, "irq_en_rd");

        // Input channel 1 change: visible on the third read, flag and irq follow
        in_data = 16'h5A00;
        rd(32'h8000_0004, 32'h0, "in1_lat0");
        rd(32'h8000_0004, 32'h0, "in1_lat1");
        rd(32'h8000_0004, 32'h5A, "in1_lat2");
        chk("irq_pre", irq, 0);
        rd(32'h8000_003C, 32'h2, "status_set");
        chk("irq_rise", irq, 1);
        rd(32'h8000_0000, 32'h0, "in0_still0");

        // Clear coinciding with a new change: set wins
        in_data = 16'h3300;
        idle(2);
        wr(32'h8000_003C, 32'h2, 4'hF);
        rd(32'h8000_003C, 32'h2, "status_set_wins");
        chk("irq_set_wins", irq, 1);
        wr(32'h8000_003C, 32'h2, 4'hF);
        chk("irq_hold", irq, 1);
        rd(32'h8000_003C, 32'h0, "status_clr");
        chk("irq_fall", irq, 0);

        // Channel 0 flag is masked off by IRQ_EN
        in_data = 16'h3301;
        idle(3);
        rd(32'h8000_003C, 32'h1, "status_ch0");
        chk("irq_masked", irq, 0);
        wr(32'h8000_003C, 32'h1, 4'hF);
        rd(32'h8000_003C, 32'h0, "status_ch0_clr");

        // Reset with accesses presented during it
        in_data = 16'h0000;
        idle(5);
        rst_n = 1'b0;
        access(1'b1, 4'hF, 32'h8000_000C, 32'h0000_BEEF, 1'b1, 32'h0, "rst_rd_io");
        chk("rst_out_upd_abort", out_upd, 0);
        chk("rst_out_data_clr", out_data, 0);
        chk("rst_irq_clr", irq, 0);
        access(1'b1, 4'hF, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 32'h0, "rst_rd_ram");
        chk("rst_out_upd2", out_upd, 0);
        rst_n = 1'b1;
        rd(32'h0000_0100, 32'h00AD_00EF, "ram_keep_100");
        rd(32'h0000_0104, 32'h2222_2222, "ram_keep_104");
        rd(32'h0000_0208, rnd[2], "ram_keep_rand");
        rd(32'h8000_0038, 32'h0, "irq_en_rst");
        rd(32'h8000_003C, 32'h0, "status_rst");
        rd(32'h8000_000C, 32'h0, "out1_rst");
        rd(32'h8000_0004, 32'h0, "in1_rst");
        chk("out_upd_post_rst", out_upd, 0);
        idle(2);
        chk("sb_drain", due_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
